// File: rtl/matmul_feeder_pkg.sv
// matmul_feeder_pkg: constants, FSM encoding and skew index helper shared by the matmul feeder
package matmul_feeder_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int N = 4;
  localparam int ROW_W = $clog2(N);
  localparam int FEED_LEN = 7;
  localparam int CNT_W = 4;
  typedef enum logic [2:0] {IDLE, START, FEED, DRAIN, DONE} state_t;
  function automatic int skew_k(input int i, input int c);
    return N + i - c;
  endfunction
endpackage

// File: rtl/matmul_feeder_if.sv
// matmul_feeder_if: host load/read, control and systolic-array signals of the matmul feeder
interface matmul_feeder_if #(parameter int DATA_W = 32);
  logic ld_valid;
  logic ld_ready;
  logic ld_sel;
  logic [1:0] ld_row;
  logic [4*DATA_W-1:0] ld_data;
  logic start;
  logic busy;
  logic done;
  logic err;
  logic [1:0] rd_row;
  logic [4*DATA_W-1:0] rd_data;
  logic mm_input_start;
  logic [3:0] mm_counter;
  logic [4*DATA_W-1:0] mm_inA_flat;
  logic [4*DATA_W-1:0] mm_inB_flat;
  logic mm_output_rdy;
  logic [4*DATA_W-1:0] mm_outD_flat;
  modport slave(
    input ld_valid, ld_sel, ld_row, ld_data, start, rd_row, mm_output_rdy, mm_outD_flat,
    output ld_ready, busy, done, err, rd_data, mm_input_start, mm_counter, mm_inA_flat, mm_inB_flat
  );
  modport master(
    output ld_valid, ld_sel, ld_row, ld_data, start, rd_row, mm_output_rdy, mm_outD_flat,
    input ld_ready, busy, done, err, rd_data, mm_input_start, mm_counter, mm_inA_flat, mm_inB_flat
  );
endinterface

// File: rtl/matmul_feeder_skew_mux.sv
// matmul_skew_mux: picks the diagonal-skewed A/B element for each lane from the feed counter
module matmul_skew_mux
  import matmul_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [CNT_W-1:0]    cnt,
  input  logic [N*DATA_W-1:0] a [N],
  input  logic [N*DATA_W-1:0] b [N],
  output logic [N*DATA_W-1:0] lane_a,
  output logic [N*DATA_W-1:0] lane_b
);
  int k;
  always_comb begin
    k = 0;
    lane_a = '0;
    lane_b = '0;
    for (int i = 0; i < N; i++) begin
      k = skew_k(i, int'(cnt));
      if (int'(cnt) >= 1 && int'(cnt) <= FEED_LEN && k >= 0 && k < N) begin
        lane_a[(N-i)*DATA_W-1 -: DATA_W] = a[ROW_W'(i)][(N-k)*DATA_W-1 -: DATA_W];
        lane_b[(N-i)*DATA_W-1 -: DATA_W] = b[ROW_W'(k)][(N-i)*DATA_W-1 -: DATA_W];
      end
    end
  end
endmodule

// File: rtl/matmul_feeder.sv
// matmul_feeder: buffers A/B, drives the skewed 4x4 systolic feed and collects result rows.
// Optional missing-row timeout enabled by defining MATMUL_FEED_TIMEOUT_EN.
module matmul_feeder
  import matmul_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
`ifdef MATMUL_FEED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input logic clk,
  input logic rst,
  matmul_feeder_if.slave bus
);
  state_t state, state_n;
  logic [N*DATA_W-1:0] a_buf [N];
  logic [N*DATA_W-1:0] b_buf [N];
  logic [N*DATA_W-1:0] res [N];
  logic [ROW_W:0] row_idx;
  logic [CNT_W-1:0] cnt, cnt_n, feed_cnt;
  logic [N*DATA_W-1:0] lane_a, lane_b, in_a, in_b;
  logic run, cap, rows_done, tmo;
  assign run = state inside {START, FEED, DRAIN};
  assign cap = run && bus.mm_output_rdy && row_idx < (ROW_W+1)'(N);
  assign rows_done = row_idx == (ROW_W+1)'(N) || (cap && row_idx == (ROW_W+1)'(N-1));
`ifdef MATMUL_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tcnt;
  logic err_q;
  assign tmo = run && tcnt == TW'(TIMEOUT_CYC - 1);
  assign bus.err = err_q;
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tcnt <= '0;
    else if (run) tcnt <= tcnt + TW'(1);
    if (rst || (state == IDLE && bus.start)) err_q <= 1'b0;
    else if (tmo && !rows_done) err_q <= 1'b1;
  end
`else
  assign tmo = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? START : IDLE;
      START:   state_n = FEED;
      FEED:    state_n = cnt == CNT_W'(FEED_LEN) ? DRAIN : FEED;
      DRAIN:   state_n = rows_done ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
    if (tmo) state_n = DONE;
  end
  always_comb begin
    bus.ld_ready = state == IDLE;
    bus.busy = run;
    bus.done = state == DONE;
    bus.mm_input_start = state == START;
    cnt_n = state_n inside {FEED, DRAIN} ? cnt + CNT_W'(1) : '0;
    feed_cnt = state_n == FEED ? cnt_n : '0;
  end
  assign bus.mm_counter = cnt;
  assign bus.mm_inA_flat = in_a;
  assign bus.mm_inB_flat = in_b;
  assign bus.rd_data = res[bus.rd_row];
  matmul_skew_mux #(.DATA_W(DATA_W)) u_skew (
    .cnt(feed_cnt),
    .a(a_buf),
    .b(b_buf),
    .lane_a(lane_a),
    .lane_b(lane_b)
  );
  // Lanes are registered from the next counter value so they change on the counter's edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i] <= '0;
        b_buf[i] <= '0;
        res[i] <= '0;
      end
      row_idx <= '0;
      cnt <= '0;
      in_a <= '0;
      in_b <= '0;
    end else begin
      if (bus.ld_ready && bus.ld_valid) begin
        if (bus.ld_sel) b_buf[bus.ld_row] <= bus.ld_data;
        else a_buf[bus.ld_row] <= bus.ld_data;
      end
      if (state == IDLE && bus.start) row_idx <= '0;
      else if (cap) begin
        res[row_idx[ROW_W-1:0]] <= bus.mm_outD_flat;
        row_idx <= row_idx + (ROW_W+1)'(1);
      end
      cnt <= cnt_n;
      in_a <= lane_a;
      in_b <= lane_b;
    end
  end
endmodule
